// File: rtl/demod_pkg.sv
// Shared encodings for the demod output scheduler.
// Mode codes, DAC levels and scheduler state.
package demod_pkg;

  localparam logic [1:0] MODE_AM   = 2'd0;
  localparam logic [1:0] MODE_FSK  = 2'd1;
  localparam logic [1:0] MODE_ADC  = 2'd2;
  localparam logic [1:0] MODE_IDLE = 2'd3;

  localparam logic [13:0] DAC_MID = 14'h2000;
  localparam logic [13:0] FSK_HI  = 14'h1FFF;
  localparam logic [13:0] FSK_LO  = 14'h0000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MUTE,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/demod_out_sched_fsk_deglitch.sv
// FSK decision deglitcher: fsk_q follows fsk_bit only after
// DEGLITCH consecutive disagreeing samples.
module fsk_deglitch #(
  parameter int DEGLITCH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic fsk_bit,
  output logic fsk_q
);

  localparam int W = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;
  localparam logic [W-1:0] LAST = W'(DEGLITCH - 1);

  logic [W-1:0] dg_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsk_q  <= 1'b0;
      dg_cnt <= '0;
    end else if (sample_en) begin
      if (fsk_bit == fsk_q) begin
        dg_cnt <= '0;
      end else if (dg_cnt == LAST) begin
        fsk_q  <= ~fsk_q;
        dg_cnt <= '0;
      end else begin
        dg_cnt <= dg_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demod_out_sched.sv
// Shares the DAC between demod sources; mutes to midscale
// across source switches while the new chain settles.
module demod_out_sched
  import demod_pkg::*;
#(
  parameter int         SETTLE_SAMPLES = 64,
  parameter int         DEGLITCH       = 4,
  parameter logic [1:0] RESET_MODE     = 2'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [1:0]  mode_req,
  input  logic        mode_req_valid,
  input  logic [13:0] am_data,
  input  logic        fsk_bit,
  input  logic [11:0] adc_data,
  output logic [13:0] dac_data,
  output logic [1:0]  mode_cur,
  output logic        busy,
  output logic        mode_ack
);

  localparam int CW =
    (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_SAMPLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    pending;
  logic          fsk_q;
  logic          req_new;
  logic          pass;
  logic [13:0]   src_data;

  fsk_deglitch #(
    .DEGLITCH (DEGLITCH)
  ) u_dg (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .fsk_bit   (fsk_bit),
    .fsk_q     (fsk_q)
  );

  assign req_new = mode_req_valid && (mode_req != mode_cur);
  // A switching request wins over a coincident strobe.
  assign pass = (state == ST_RUN) && !req_new;

  always_comb begin
    src_data = DAC_MID;
    unique case (1'b1)
      mode_cur == MODE_AM:   src_data = am_data;
      mode_cur == MODE_FSK:  src_data = fsk_q ? FSK_HI : FSK_LO;
      mode_cur == MODE_ADC:  src_data = {adc_data, 2'b00};
      mode_cur == MODE_IDLE: src_data = DAC_MID;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_SETTLE;
      mode_cur <= RESET_MODE;
      pending  <= RESET_MODE;
      cnt      <= '0;
      dac_data <= DAC_MID;
      busy     <= 1'b1;
      mode_ack <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (req_new) begin
            pending <= mode_req;
            state   <= ST_MUTE;
            busy    <= 1'b1;
          end else if (mode_req_valid) begin
            mode_ack <= 1'b1;
          end
        end
        ST_MUTE: begin
          if (mode_req_valid) begin
            pending <= mode_req;
          end
          if (sample_en) begin
            mode_cur <= mode_req_valid ? mode_req : pending;
            cnt      <= '0;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (req_new) begin
            mode_cur <= mode_req;
            cnt      <= '0;
          end else if (sample_en) begin
            if (cnt == CNT_LAST) begin
              state    <= ST_RUN;
              busy     <= 1'b0;
              mode_ack <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_SETTLE;
      endcase
      if (sample_en) begin
        dac_data <= pass ? src_data : DAC_MID;
      end
    end
  end

endmodule

// File: tb/tb_demod_out_sched.sv
// Bench for demod_out_sched: directed table, corner sequences
// and random traffic against a behavioural reference model.
module tb_demod_out_sched;

  localparam int         SETTLE = 64;
  localparam int         DG     = 4;
  localparam logic [1:0] RMODE  = 2'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [1:0]  mode_req = 2'd0;
  logic        mode_req_valid = 1'b0;
  logic [13:0] am_data = 14'h1234;
  logic        fsk_bit = 1'b0;
  logic [11:0] adc_data = 12'hABC;
  logic [13:0] dac_data;
  logic [1:0]  mode_cur;
  logic        busy;
  logic        mode_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  demod_out_sched #(
    .SETTLE_SAMPLES (SETTLE),
    .DEGLITCH       (DG),
    .RESET_MODE     (RMODE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_en      (sample_en),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .am_data        (am_data),
    .fsk_bit        (fsk_bit),
    .adc_data       (adc_data),
    .dac_data       (dac_data),
    .mode_cur       (mode_cur),
    .busy           (busy),
    .mode_ack       (mode_ack)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = passing, 1 = muted waiting, 2 = settling
  int          m_phase;
  logic [1:0]  m_mode;
  logic [1:0]  m_pend;
  int          m_left;
  logic        m_fsk;
  int          m_run;
  logic [13:0] m_dac;
  logic        m_busy;
  logic        m_ack;

  function automatic void model_reset();
    m_phase = 2;
    m_mode  = RMODE;
    m_pend  = RMODE;
    m_left  = SETTLE;
    m_fsk   = 1'b0;
    m_run   = 0;
    m_dac   = 14'h2000;
    m_busy  = 1'b1;
    m_ack   = 1'b0;
  endfunction

  function automatic void model_step();
    logic [13:0] src;
    bit          sw;
    sw = mode_req_valid && (mode_req != m_mode);
    case (m_mode)
      2'd0:    src = am_data;
      2'd1:    src = m_fsk ? 14'h1FFF : 14'h0000;
      2'd2:    src = {adc_data, 2'b00};
      default: src = 14'h2000;
    endcase
    if (sample_en)
      m_dac = (m_phase == 0 && !sw) ? src : 14'h2000;
    m_ack = 1'b0;
    if (m_phase == 0) begin
      if (sw) begin
        m_pend = mode_req;
        m_phase = 1;
      end else if (mode_req_valid) begin
        m_ack = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (mode_req_valid) m_pend = mode_req;
      if (sample_en) begin
        m_mode = m_pend;
        m_left = SETTLE;
        m_phase = 2;
      end
    end else begin
      if (sw) begin
        m_mode = mode_req;
        m_left = SETTLE;
      end else if (sample_en) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_phase = 0;
          m_ack = 1'b1;
        end
      end
    end
    m_busy = (m_phase != 0);
    if (sample_en) begin
      if (fsk_bit != m_fsk) begin
        m_run = m_run + 1;
        if (m_run == DG) begin
          m_fsk = ~m_fsk;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h",
               name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("dac_data", 32'(dac_data), 32'(m_dac));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("mode_ack", 32'(mode_ack), 32'(m_ack));
    chk("mode_cur", 32'(mode_cur), 32'(m_mode));
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  // One sample period: strobe clk then three quiet clks.
  task automatic period(input logic v, input logic [1:0] req);
    sample_en = 1'b1;
    mode_req_valid = v;
    mode_req = req;
    tick();
    sample_en = 1'b0;
    mode_req_valid = 1'b0;
    repeat (3) tick();
  endtask

  typedef struct {
    int          n;
    logic        v;
    logic        same;
    logic [1:0]  req;
    logic        fb;
    logic [13:0] e_dac;
    logic        e_busy;
    logic [1:0]  e_mode;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, logic v, logic same,
                              logic [1:0] req, logic fb,
                              logic [13:0] ed, logic eb,
                              logic [1:0] em);
    vec_t r;
    r.n = n; r.v = v; r.same = same; r.req = req; r.fb = fb;
    r.e_dac = ed; r.e_busy = eb; r.e_mode = em;
    return r;
  endfunction

  initial begin
    tbl.push_back(mk(63, 0, 0, 0, 0, 14'h2000, 1, 1));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 14'h2000, 0, 1));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 14'h0000, 0, 1));
    tbl.push_back(mk( 3, 0, 0, 0, 1, 14'h0000, 0, 1));
    tbl.push_back(mk( 2, 0, 0, 0, 0, 14'h0000, 0, 1));
    tbl.push_back(mk( 4, 0, 0, 0, 1, 14'h0000, 0, 1));
    tbl.push_back(mk( 1, 0, 0, 0, 1, 14'h1FFF, 0, 1));
    tbl.push_back(mk( 1, 1, 0, 2, 1, 14'h2000, 1, 2));
    tbl.push_back(mk(63, 0, 0, 0, 1, 14'h2000, 1, 2));
    tbl.push_back(mk( 1, 0, 0, 0, 1, 14'h2000, 0, 2));
    tbl.push_back(mk( 1, 0, 0, 0, 1, 14'h2AF0, 0, 2));
    tbl.push_back(mk( 1, 1, 0, 1, 1, 14'h2000, 1, 1));
    tbl.push_back(mk(30, 0, 0, 0, 1, 14'h2000, 1, 1));
    tbl.push_back(mk(63, 1, 0, 0, 1, 14'h2000, 1, 0));
    tbl.push_back(mk( 1, 0, 0, 0, 1, 14'h2000, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 0, 1, 14'h1234, 0, 0));
    tbl.push_back(mk( 1, 1, 1, 3, 1, 14'h2000, 1, 0));
    tbl.push_back(mk( 1, 0, 0, 0, 1, 14'h2000, 1, 3));
    tbl.push_back(mk(63, 0, 0, 0, 1, 14'h2000, 1, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 1, 14'h2000, 0, 3));
    tbl.push_back(mk( 1, 0, 0, 0, 1, 14'h2000, 0, 3));
    tbl.push_back(mk( 1, 1, 0, 3, 1, 14'h2000, 0, 3));
    tbl.push_back(mk( 1, 1, 1, 0, 1, 14'h2000, 1, 3));

    model_reset();
    repeat (3) tick();
    chk("reset dac", 32'(dac_data), 32'h2000);
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset mode", 32'(mode_cur), 32'(RMODE));
    rst = 1'b0;

    foreach (tbl[i]) begin
      fsk_bit = tbl[i].fb;
      if (tbl[i].v && !tbl[i].same) begin
        mode_req = tbl[i].req;
        mode_req_valid = 1'b1;
        sample_en = 1'b0;
        tick();
        mode_req_valid = 1'b0;
      end
      for (int k = 0; k < tbl[i].n; k++)
        period(k == 0 && tbl[i].v && tbl[i].same, tbl[i].req);
      chk($sformatf("row%0d dac", i), 32'(dac_data),
          32'(tbl[i].e_dac));
      chk($sformatf("row%0d busy", i), 32'(busy),
          32'(tbl[i].e_busy));
      chk($sformatf("row%0d mode", i), 32'(mode_cur),
          32'(tbl[i].e_mode));
    end

    // Into SETTLE on AM, then reset with no strobe and no edge.
    repeat (5) period(1'b0, 2'd0);
    chk("pre-rst mode", 32'(mode_cur), 32'd0);
    rst = 1'b1;
    #2;
    chk("async rst dac", 32'(dac_data), 32'h2000);
    chk("async rst busy", 32'(busy), 32'd1);
    chk("async rst ack", 32'(mode_ack), 32'd0);
    chk("async rst mode", 32'(mode_cur), 32'(RMODE));
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    for (int c = 0; c < 6000; c++) begin
      sample_en = ($urandom_range(2) == 0);
      mode_req_valid = ($urandom_range(39) == 0);
      mode_req = 2'($urandom);
      am_data = 14'($urandom);
      adc_data = 12'($urandom);
      if ($urandom_range(23) == 0) fsk_bit = ~fsk_bit;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/demod_out_sched.md
# demod_out_sched

Output scheduler that shares the single AD9764 DAC path between the demodulator sources: AM demod output, FSK bit decision, raw AD9226 passthrough and a midscale idle level. Sits between the demod datapaths and the DAC driver, running on the system clock with a per-ADC-sample enable strobe. On a mode change it mutes the DAC to midscale and holds it there while the newly selected filter chain settles, so no glitch reaches the DAC. It also deglitches the FSK sign decision before it drives the DAC.

## Interface
- SETTLE_SAMPLES, 64: sample_en strobes the output is held muted after a source switch (≥1).
- DEGLITCH, 4: consecutive sample_en strobes `fsk_bit` must disagree with the current FSK output before that output flips (≥1).
- RESET_MODE, 2'd1: source selected out of reset (0 AM, 1 FSK, 2 ADC raw, 3 idle).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  one-clk strobe per ADC sample.
- mode_req  in  2  requested source (0 AM, 1 FSK, 2 ADC raw, 3 idle).
- mode_req_valid  in  1  one-clk request strobe.
- am_data  in  14  AM demod output, unsigned offset binary.
- fsk_bit  in  1  FSK decision, 1 = mark (sign of filtered mix inverted).
- adc_data  in  12  AD9226 sample, unsigned.
- dac_data  out  14  to DAC driver, registered.
- mode_cur  out  2  source currently selected or settling.
- busy  out  1  high in MUTE or SETTLE.
- mode_ack  out  1  one-clk pulse on entry to RUN.

## Operation
- Source map in RUN:
  - AM: dac_data = am_data.
  - FSK: dac_data = fsk_q ? 14'h1FFF : 14'h0000.
  - ADC: dac_data = {adc_data, 2'b00}.
  - Idle: dac_data = 14'h2000.
- MUTE and SETTLE always drive 14'h2000.
- The FSM has three states: RUN, MUTE and SETTLE.
- Transitions out of RUN:
  - mode_req_valid with mode_req ≠ mode_cur: latch pending = mode_req, go to MUTE.
  - mode_req_valid with mode_req = mode_cur: mode_ack pulses next clk, stay in RUN.
- MUTE:
  - A new mode_req_valid overwrites pending.
  - On the next sample_en: mode_cur ← pending, cnt ← 0, go to SETTLE.
- SETTLE:
  - Each sample_en increments cnt.
  - A sample_en with cnt = SETTLE_SAMPLES−1 goes to RUN and pulses mode_ack.
  - mode_req_valid with mode_req ≠ mode_cur: mode_cur ← mode_req, cnt ← 0 (restart settle). A request equal to mode_cur is ignored.
- If mode_req_valid and sample_en occur in the same clk, the request is processed first. Example: in RUN, both together produce MUTE now and SETTLE at the next sample_en, not this one.
- FSK deglitch runs in every mode, so fsk_q is valid on entry to FSK.
  - On sample_en, if fsk_bit ≠ fsk_q: dg_cnt++. When dg_cnt reaches DEGLITCH−1, flip fsk_q and clear dg_cnt.
  - On sample_en, if fsk_bit = fsk_q: dg_cnt ← 0.
- Counters are sized by $clog2 of the parameter and never wrap past their terminal value.

## Timing
- Reset values:
  - state = SETTLE, mode_cur = RESET_MODE, cnt = 0.
  - dac_data = 14'h2000, busy = 1, mode_ack = 0.
  - fsk_q = 0, dg_cnt = 0, pending = RESET_MODE.
- dac_data updates only on clks with sample_en, one clk later (registered). It holds between strobes.
- Sources are sampled in the same clk as sample_en.
- busy rises the clk after an accepted request.
- busy falls together with the mode_ack pulse, one clk after the final settle sample_en.
- Muted duration after a request in RUN: 1 to 2 sample periods for MUTE, plus SETTLE_SAMPLES sample periods.
- FSK decision latency: DEGLITCH sample_en strobes from a stable fsk_bit change to the fsk_q flip. dac_data follows one sample later, because fsk_q is registered before the output register.
- Reset asserted mid-operation returns to the reset values immediately, with no sample_en needed.

## Structure
- Shared package `demod_pkg`:
  - Mode encodings MODE_AM/MODE_FSK/MODE_ADC/MODE_IDLE.
  - DAC_MID = 14'h2000, FSK_HI = 14'h1FFF, FSK_LO = 14'h0000.
  - State enum.
- Sub-module `fsk_deglitch` (clk, rst, sample_en, fsk_bit, DEGLITCH → fsk_q).
- Top contains the FSM, settle counter and output mux/register.

## Test plan
- Release reset with RESET_MODE=1 and SETTLE_SAMPLES=64, 1 strobe per 4 clk. Required: dac_data = 14'h2000 for 64 strobes, then mode_ack, busy=0, and FSK levels.
- In FSK RUN, drive fsk_bit 0→1 held. Required: fsk_q flips after 4 strobes and dac_data = 14'h1FFF one sample later. A 3-sample pulse of 1 must produce no change.
- In RUN, request ADC (2) with adc_data = 12'hABC. Required: 14'h2000 through MUTE+SETTLE, then 14'h2AF0, mode_ack pulses once.
- In SETTLE at cnt = 30, request AM. Required: cnt restarts, mode_cur = 0, full 64 further muted strobes, then am_data passes.
- In RUN, assert mode_req_valid and sample_en in the same clk. Required: the output on that strobe is midscale. A same-mode request produces an ack with busy staying 0.
- Assert rst mid-SETTLE. Required: all outputs at reset values the next clk edge, with no sample_en needed.
